// File: rtl/clk_gate_ctrl.sv
// Enable generator for one tc_clk_gating cell: idle-qualified clock-off, settle-timed clock-on,
// driven by a 4-phase req/ack handshake from the power manager. Lives in the always-on domain.
module clk_gate_ctrl #(
    parameter int IDLE_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8,
    parameter int STAT_W        = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              gate_req_i,
    output logic              gate_ack_o,
    input  logic              busy_i,
    input  logic              wake_i,
    output logic              wake_pending_o,
    input  logic              scan_mode_i,
    output logic              en_o,
    output logic              test_en_o,
    output logic [STAT_W-1:0] off_cycles_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_OFF   = 2'd2,
        ST_WAKE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] IDLE_LIM   = CNT_W'(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LIM = CNT_W'(SETTLE_CYCLES - 1);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               wake_pend_d;
    logic               leave_off;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        sat_inc = (&v) ? v : v + STAT_W'(1);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (gate_req_i) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end
            end
            ST_DRAIN: begin
                // Abort takes precedence over busy so a withdrawn request never gates.
                if (!gate_req_i) begin
                    state_d = ST_RUN;
                end else if (busy_i) begin
                    cnt_d = '0;
                end else if (cnt_q == IDLE_LIM) begin
                    state_d = ST_OFF;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_OFF: begin
                if (!gate_req_i) begin
                    state_d = ST_WAKE;
                    cnt_d   = '0;
                end
            end
            ST_WAKE: begin
                if (cnt_q == SETTLE_LIM) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    assign leave_off = (state_q == ST_OFF) && (state_d != ST_OFF);

    always_comb begin
        wake_pend_d = wake_pending_o;
        if (leave_off) begin
            wake_pend_d = 1'b0;
        end else if ((state_q == ST_OFF) && wake_i) begin
            wake_pend_d = 1'b1;
        end
    end

    // Outputs are registered from the next state so they change on the same edge as the FSM.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_RUN;
            cnt_q          <= '0;
            en_o           <= 1'b1;
            gate_ack_o     <= 1'b0;
            wake_pending_o <= 1'b0;
            off_cycles_o   <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            en_o           <= (state_d != ST_OFF);
            gate_ack_o     <= (state_d == ST_OFF) || (state_d == ST_WAKE);
            wake_pending_o <= wake_pend_d;
            if (state_q == ST_OFF) begin
                off_cycles_o <= sat_inc(off_cycles_o);
            end
        end
    end

    assign test_en_o = scan_mode_i;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Self-checking bench for clk_gate_ctrl: directed handshake scenarios plus randomized traffic
// against a behavioural model phrased in terms of idle-cycle and settle-cycle counts.
module tb_clk_gate_ctrl;

    localparam int IDLE_CYCLES   = 4;
    localparam int SETTLE_CYCLES = 2;
    localparam int CNT_W         = 8;
    localparam int STAT_W        = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req = 1'b0;
    logic              busy = 1'b0;
    logic              wake = 1'b0;
    logic              scan = 1'b0;
    logic              gate_ack_o;
    logic              wake_pending_o;
    logic              en_o;
    logic              test_en_o;
    logic [STAT_W-1:0] off_cycles_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Behavioural model
    bit                m_is_off;
    bit                m_draining;
    int                m_idle_seen;
    int                m_settle_left;
    bit                m_wp;
    logic [STAT_W-1:0] m_off_cnt;
    bit                m_en;
    bit                m_ack;

    clk_gate_ctrl #(
        .IDLE_CYCLES  (IDLE_CYCLES),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .CNT_W        (CNT_W),
        .STAT_W       (STAT_W)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .gate_req_i    (req),
        .gate_ack_o    (gate_ack_o),
        .busy_i        (busy),
        .wake_i        (wake),
        .wake_pending_o(wake_pending_o),
        .scan_mode_i   (scan),
        .en_o          (en_o),
        .test_en_o     (test_en_o),
        .off_cycles_o  (off_cycles_o)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        if (rst) begin
            m_is_off      = 0;
            m_draining    = 0;
            m_idle_seen   = 0;
            m_settle_left = 0;
            m_wp          = 0;
            m_off_cnt     = '0;
        end else if (m_is_off) begin
            if (m_off_cnt != {STAT_W{1'b1}}) m_off_cnt = m_off_cnt + 1;
            if (!req) begin
                m_is_off      = 0;
                m_settle_left = SETTLE_CYCLES;
                m_wp          = 0;
            end else if (wake) begin
                m_wp = 1;
            end
        end else if (m_settle_left > 0) begin
            m_settle_left--;
        end else if (m_draining) begin
            if (!req) begin
                m_draining = 0;
            end else if (busy) begin
                m_idle_seen = 0;
            end else begin
                m_idle_seen++;
                if (m_idle_seen == IDLE_CYCLES + 1) begin
                    m_draining = 0;
                    m_is_off   = 1;
                end
            end
        end else if (req) begin
            m_draining  = 1;
            m_idle_seen = 0;
        end
        m_en  = !m_is_off;
        m_ack = m_is_off || (m_settle_left > 0);
    endtask

    // Inputs are stable across the edge; the model consumes the same values the DUT samples.
    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; busy = 1'b0; wake = 1'b0;
        tick();
        tick();
        total++; if (en_o !== 1'b1) begin bad++; $display("FAIL reset_en got=%b want=1", en_o); end
        total++; if (gate_ack_o !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b want=0", gate_ack_o); end
        total++; if (off_cycles_o !== '0) begin bad++; $display("FAIL reset_off got=%0d want=0", off_cycles_o); end
        total++; if (wake_pending_o !== 1'b0) begin bad++; $display("FAIL reset_wp got=%b want=0", wake_pending_o); end
        rst = 1'b0;
        tick();
        total++; if (en_o !== 1'b1 || gate_ack_o !== 1'b0) begin bad++; $display("FAIL reset_run got=%b%b want=10", en_o, gate_ack_o); end
    endtask

    task automatic test_gate();
        req = 1'b1;
        for (int i = 1; i <= IDLE_CYCLES + 3; i++) begin
            tick();
            total++;
            if ({en_o, gate_ack_o} !== ((i >= IDLE_CYCLES + 2) ? 2'b01 : 2'b10)) begin
                bad++; $display("FAIL gate_latency i=%0d got=%b%b want=%b", i, en_o, gate_ack_o,
                                (i >= IDLE_CYCLES + 2) ? 2'b01 : 2'b10);
            end
            total++;
            if ({en_o, gate_ack_o, wake_pending_o} !== {m_en, m_ack, m_wp}) begin
                bad++; $display("FAIL gate_model cyc=%0d got=%b%b%b want=%b%b%b", cyc,
                                en_o, gate_ack_o, wake_pending_o, m_en, m_ack, m_wp);
            end
        end
    endtask

    task automatic test_wake();
        req = 1'b0;
        for (int i = 1; i <= SETTLE_CYCLES + 2; i++) begin
            tick();
            total++;
            if ({en_o, gate_ack_o} !== {1'b1, (i <= SETTLE_CYCLES)}) begin
                bad++; $display("FAIL wake_settle i=%0d got=%b%b want=1%b", i, en_o, gate_ack_o, (i <= SETTLE_CYCLES));
            end
            total++;
            if (off_cycles_o !== m_off_cnt) begin
                bad++; $display("FAIL wake_offcnt cyc=%0d got=%0d want=%0d", cyc, off_cycles_o, m_off_cnt);
            end
        end
    endtask

    task automatic test_busy_restart();
        req = 1'b1;
        for (int i = 1; i <= IDLE_CYCLES + 6; i++) begin
            busy = (i == 3);
            tick();
            busy = 1'b0;
            total++;
            if (en_o !== ((i >= 3 + IDLE_CYCLES + 1) ? 1'b0 : 1'b1)) begin
                bad++; $display("FAIL busy_restart i=%0d got=%b want=%b", i, en_o, (i >= 3 + IDLE_CYCLES + 1) ? 1'b0 : 1'b1);
            end
        end
        test_wake();
    endtask

    task automatic test_abort();
        req = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            req = (i <= 2);
            tick();
            total++;
            if ({en_o, gate_ack_o} !== 2'b10) begin
                bad++; $display("FAIL abort i=%0d got=%b%b want=10", i, en_o, gate_ack_o);
            end
        end
        // Abort coincident with busy still returns to RUN and a fresh request needs a full idle run.
        req = 1'b1; tick();
        busy = 1'b1; req = 1'b0; tick();
        busy = 1'b0;
        total++; if ({en_o, gate_ack_o} !== {m_en, m_ack}) begin bad++; $display("FAIL abort_busy got=%b%b want=%b%b", en_o, gate_ack_o, m_en, m_ack); end
        tick();
    endtask

    task automatic test_wake_pending();
        req = 1'b1;
        repeat (IDLE_CYCLES + 2) tick();
        wake = 1'b1; tick(); wake = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (wake_pending_o !== 1'b1) begin bad++; $display("FAIL wp_sticky i=%0d got=%b want=1", i, wake_pending_o); end
        end
        req = 1'b0; tick();
        total++; if (wake_pending_o !== 1'b0) begin bad++; $display("FAIL wp_clear got=%b want=0", wake_pending_o); end
        repeat (SETTLE_CYCLES + 1) tick();
        wake = 1'b1; tick(); wake = 1'b0;
        total++; if (wake_pending_o !== 1'b0) begin bad++; $display("FAIL wp_outside_off got=%b want=0", wake_pending_o); end
        req = 1'b1;
        repeat (IDLE_CYCLES + 4) tick();
        total++; if (en_o !== 1'b0) begin bad++; $display("FAIL wp_regate got=%b want=0", en_o); end
        rst = 1'b1; tick(); rst = 1'b0; req = 1'b0;
        total++; if (en_o !== 1'b1) begin bad++; $display("FAIL rst_mid_off_en got=%b want=1", en_o); end
        total++; if (off_cycles_o !== '0) begin bad++; $display("FAIL rst_mid_off_cnt got=%0d want=0", off_cycles_o); end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 8) req = ~req;
            busy = ($urandom_range(0, 99) < 25);
            wake = ($urandom_range(0, 99) < 10);
            scan = ($urandom_range(0, 99) < 5);
            rst  = ($urandom_range(0, 999) < 5);
            tick();
            total++;
            if ({en_o, gate_ack_o, wake_pending_o} !== {m_en, m_ack, m_wp}) begin
                bad++; $display("FAIL rand_flags cyc=%0d got=%b%b%b want=%b%b%b", cyc,
                                en_o, gate_ack_o, wake_pending_o, m_en, m_ack, m_wp);
            end
            total++;
            if (off_cycles_o !== m_off_cnt) begin
                bad++; $display("FAIL rand_offcnt cyc=%0d got=%0d want=%0d", cyc, off_cycles_o, m_off_cnt);
            end
            total++;
            if (test_en_o !== scan) begin
                bad++; $display("FAIL rand_test_en cyc=%0d got=%b want=%b", cyc, test_en_o, scan);
            end
        end
        rst = 1'b0; busy = 1'b0; wake = 1'b0; scan = 1'b0;
    endtask

    initial begin
        test_reset();
        test_gate();
        test_wake();
        test_busy_restart();
        test_abort();
        test_wake_pending();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
